inst_mem_loadable: RTL and testbench

//   Parametrised instruction memory with a byte-serial boot-load port and a registered fetch port.
//   It sits between the boot/test harness (loader side) and the fetch stage (PC side).
//   It replaces file-initialised ROM content with run-time loading.
//   It flags out-of-range and not-yet-loaded fetches instead of silently truncating the address.

---
 rtl/inst_mem_loadable_pkg.sv | 19 +
 rtl/inst_mem_loadable_packer.sv | 66 ++++++
 rtl/inst_mem_loadable.sv | 139 +++++++++++++
 tb/tb_inst_mem_loadable.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory.
package inst_mem_loadable_pkg;

  localparam int unsigned IMEM_IW     = 32;
  localparam int unsigned IMEM_AW     = 6;
  localparam int unsigned IMEM_PCW    = 16;
  localparam int unsigned IMEM_LOAD_W = 8;
  localparam int unsigned LANES       = IMEM_IW / IMEM_LOAD_W;

  typedef logic [IMEM_IW-1:0]  Instruction;
  typedef logic [IMEM_PCW-1:0] ProgramCounter;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

endpackage

// File: rtl/inst_mem_loadable_packer.sv
// Assembles LOAD_W-wide loader beats into IW-wide words (little-endian lanes).
// The completed word is presented combinationally in the cycle of its final
// beat so the caller can write it on that same edge; unfilled lanes read 0.
module load_word_packer
  import inst_mem_loadable_pkg::*;
#(
  parameter int unsigned IW     = IMEM_IW,
  parameter int unsigned LOAD_W = IMEM_LOAD_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              beat_valid_i,
  input  logic [LOAD_W-1:0] beat_data_i,
  input  logic              beat_last_i,
  output logic [IW-1:0]     word_o,
  output logic              word_we_o
);

  localparam int unsigned NLANES = IW / LOAD_W;
  localparam int unsigned CW     = (NLANES > 1) ? $clog2(NLANES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] buf_q, buf_d;
  logic          full;

  // Merge the current beat into its lane; buffer lanes above it are still 0.
  always_comb begin
    word_o = buf_q;
    for (int unsigned l = 0; l < NLANES; l++) begin
      if (CW'(l) == cnt_q) word_o[l*LOAD_W +: LOAD_W] = beat_data_i;
    end
    full      = (cnt_q == CW'(NLANES - 1));
    word_we_o = beat_valid_i && (full || beat_last_i);
  end

  // Lane counter / partial-word buffer update; both empty after each emitted word.
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clear_i) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (beat_valid_i) begin
      if (word_we_o) begin
        cnt_d = '0;
        buf_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        buf_d = word_o;
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/inst_mem_loadable.sv
// Instruction memory with byte-serial boot loading and a registered,
// fully pipelined fetch port that flags out-of-range / unloaded addresses.
module inst_mem_loadable
  import inst_mem_loadable_pkg::*;
#(
  parameter int unsigned IW     = IMEM_IW,
  parameter int unsigned AW     = IMEM_AW,
  parameter int unsigned PCW    = IMEM_PCW,
  parameter int unsigned LOAD_W = IMEM_LOAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [LOAD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [PCW-1:0]    fetch_addr,
  output logic              fetch_valid,
  output logic [IW-1:0]     fetch_instr,
  output logic              fetch_err
);

  localparam int unsigned DEPTH = 2 ** AW;

  imem_state_t   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   loaded_q, loaded_d;
  logic          done_q, done_d;
  logic          start_load;
  logic          beat_valid;
  logic [IW-1:0] pk_word;
  logic          pk_we;

  logic [IW-1:0] mem [DEPTH];

  logic          fvalid_q;
  logic          ferr_q;
  logic [IW-1:0] finstr_q;
  logic          fetch_bad;

  assign beat_valid  = load_valid && (state_q == LOAD);
  assign load_ready  = (state_q == LOAD);
  assign load_done   = done_q;
  assign fetch_valid = fvalid_q;
  assign fetch_err   = ferr_q;
  assign fetch_instr = finstr_q;

  load_word_packer #(
    .IW     (IW),
    .LOAD_W (LOAD_W)
  ) u_packer (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (start_load),
    .beat_valid_i (beat_valid),
    .beat_data_i  (load_data),
    .beat_last_i  (load_last),
    .word_o       (pk_word),
    .word_we_o    (pk_we)
  );

  // FSM next state, write pointer and loaded-word count.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    loaded_d   = loaded_q;
    done_d     = 1'b0;
    start_load = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          loaded_d   = '0;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        if (pk_we) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          loaded_d = loaded_q + 1'b1;
          if (load_last || (loaded_d == (AW+1)'(DEPTH))) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      loaded_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
    end
  end

  // Memory array write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (pk_we) mem[wr_ptr_q] <= pk_word;
  end

  // A fetch is bad unless running, in range and within the loaded image.
  always_comb begin
    fetch_bad = (state_q != RUN)
             || ((fetch_addr >> AW) != '0)
             || ({1'b0, fetch_addr[AW-1:0]} >= loaded_q);
  end

  // Registered fetch response; data holds when no request is made.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      finstr_q <= '0;
    end else begin
      fvalid_q <= fetch_req;
      if (fetch_req) begin
        ferr_q   <= fetch_bad;
        finstr_q <= fetch_bad ? '0 : mem[fetch_addr[AW-1:0]];
      end else begin
        ferr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Scoreboard bench for inst_mem_loadable (IW=32, AW=4, PCW=16, LOAD_W=8).
module tb_inst_mem_loadable;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, load_last;
  logic [7:0]  load_data;
  logic        load_ready, load_done;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_valid, fetch_err;
  logic [31:0] fetch_instr;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  exp_t        sb[$];

  inst_mem_loadable #(
    .IW     (32),
    .AW     (4),
    .PCW    (16),
    .LOAD_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] a, input logic e, input logic [31:0] ins);
    fetch_req  = 1'b1;
    fetch_addr = a;
    sb.push_back('{err: e, instr: ins});
    step();
    fetch_req = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_ready_after_start", 64'(load_ready), 64'd1);
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic expect_done_pulse(input string name);
    chk({name, "_done"}, 64'(load_done), 64'd1);
    step();
    chk({name, "_done_clear"}, 64'(load_done), 64'd0);
  endtask

  // Monitor: every response strobe is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && fetch_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch_valid: got err=%0b instr=%08h expected none",
                 fetch_err, fetch_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("fetch_err", 64'(fetch_err), 64'(e.err));
        chk("fetch_instr", 64'(fetch_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img [8];
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
    repeat (2) step();
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_fetch_err", 64'(fetch_err), 64'd0);
    chk("rst_fetch_instr", 64'(fetch_instr), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: fetch before any load
    fetch(16'd0, 1'b1, 32'h0);

    // 2: two-word image
    start_load();
    for (int i = 0; i < 8; i++) beat(img[i], i == 7);
    expect_done_pulse("img2");
    fetch(16'd0, 1'b0, 32'h12345678);
    fetch(16'd1, 1'b0, 32'hDEADBEEF);
    fetch(16'd2, 1'b1, 32'h0);

    // 3: partial last word zero-padded
    start_load();
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    beat(8'hCC, 1'b1);
    expect_done_pulse("partial");
    fetch(16'd0, 1'b0, 32'h00CCBBAA);
    fetch(16'd1, 1'b1, 32'h0);

    // 4: full depth without load_last
    start_load();
    for (int i = 0; i < 64; i++) beat(8'(i), 1'b0);
    chk("full_load_ready_low", 64'(load_ready), 64'd0);
    expect_done_pulse("full");
    beat(8'hFF, 1'b1);
    chk("beat65_no_done", 64'(load_done), 64'd0);
    fetch(16'd15, 1'b0, 32'h3F3E3D3C);
    fetch(16'd0, 1'b0, 32'h03020100);

    // 5: back-to-back fetches and range checks
    fetch_req = 1'b1; fetch_addr = 16'd0; sb.push_back('{err: 1'b0, instr: 32'h03020100});
    step();
    chk("b2b_valid0", 64'(fetch_valid), 64'd1);
    fetch_addr = 16'd1; sb.push_back('{err: 1'b0, instr: 32'h07060504});
    step();
    chk("b2b_valid1", 64'(fetch_valid), 64'd1);
    fetch_addr = 16'd0; sb.push_back('{err: 1'b0, instr: 32'h03020100});
    step();
    chk("b2b_valid2", 64'(fetch_valid), 64'd1);
    fetch_req = 1'b0;
    step();
    chk("b2b_idle_valid", 64'(fetch_valid), 64'd0);
    chk("b2b_idle_err", 64'(fetch_err), 64'd0);
    chk("b2b_instr_hold", 64'(fetch_instr), 64'h03020100);
    fetch(16'h0010, 1'b1, 32'h0);
    load_start = 1'b1;
    fetch(16'd1, 1'b0, 32'h07060504);
    load_start = 1'b0;
    chk("reload_ready", 64'(load_ready), 64'd1);

    // 6: reset in the middle of a load
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_load_ready", 64'(load_ready), 64'd0);
    chk("midrst_load_done", 64'(load_done), 64'd0);
    chk("midrst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("midrst_fetch_err", 64'(fetch_err), 64'd0);
    chk("midrst_fetch_instr", 64'(fetch_instr), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_idle_ready", 64'(load_ready), 64'd0);
    fetch(16'd0, 1'b1, 32'h0);
    start_load();
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b1);
    expect_done_pulse("reload");
    fetch(16'd0, 1'b0, 32'h44332211);
    fetch(16'd1, 1'b1, 32'h0);

    repeat (3) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
